// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
//   apb_state_e : bridge FSM states
//   apb_cmd_t   : one command-stream beat (direction, address, write data)
//   apb_rsp_t   : one response-stream beat (read data, error, timeout flag)
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB (AMBA3-style) master bridge.
// Takes one valid/ready command at a time, runs a SETUP/ACCESS APB transfer,
// and returns read data plus error/timeout status on a valid/ready response
// channel. A wait-state counter aborts ACCESS after TIMEOUT cycles so a slave
// that never raises pready cannot stall the stream.
//
// Ports:
//   pclk, presetn                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write/cmd_addr/cmd_wdata       command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata/rsp_err/rsp_timeout      response payload
//   psel/penable/pwrite/paddr/pwdata   APB request outputs
//   prdata/pready/pslverr              APB slave returns
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              to_q, to_d;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        to_d     = to_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so a completion on the last
                // allowed cycle beats the timeout.
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        to_d    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable     = (state_q == ACCESS);
    assign rsp_valid   = (state_q == RESP);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

endmodule
